// File: rtl/mio_responder_pkg.sv
// Shared definitions for the memory-mapped I/O responder: address map,
// FSM encoding and the latched request payload.
package mio_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned SW_W   = 16;
  localparam int unsigned WAIT_W = 4;

  localparam logic [ADDR_W-1:0] RAM_BASE = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] LED_ADDR = 32'hE000_0000;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 32'hF000_0000;
  localparam logic [ADDR_W-1:0] CNT_ADDR = 32'hF000_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request captured in IDLE; address kept as a word address.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:2] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic word_match(input logic [ADDR_W-1:2] waddr,
                                      input logic [ADDR_W-1:0] base);
    return waddr == base[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/mio_ram.sv
// Word-addressed data RAM: synchronous write, combinational read, no reset.
module mio_ram
  import mio_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  localparam int unsigned AW = $clog2(RAM_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mio_responder.sv
// CPU-facing MIO responder: latches one request, inserts wait states, then
// answers with a one-cycle MIO_ready strobe from RAM, LEDs, switches or counter.
module mio_responder
  import mio_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_WORDS   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [ADDR_W-1:0] Addr_out,
  input  logic [DATA_W-1:0] Data_out,
  input  logic [SW_W-1:0]   sw_in,
  output logic [DATA_W-1:0] Data_in,
  output logic              MIO_ready,
  output logic [LED_W-1:0]  led_out
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  state_e              state_q;
  req_t                req_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                ready_q;
  logic [LED_W-1:0]    led_q;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   rdata_c;
  logic                resp_c, commit_c;
  logic                hit_ram_c, hit_led_c, hit_sw_c, hit_cnt_c;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^Addr_out[1:0];

  // Request FSM; ready_q is high exactly while in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (CPU_MIO) begin
            req_q <= '{we: mem_w, addr: Addr_out[ADDR_W-1:2], wdata: Data_out};
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              wait_q  <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A reset during RESP suppresses both the strobe and the write commit.
  assign resp_c   = ready_q & ~reset;
  assign commit_c = resp_c & req_q.we;

  assign hit_ram_c = req_q.addr[ADDR_W-1:RAM_AW+2] == RAM_BASE[ADDR_W-1:RAM_AW+2];
  assign hit_led_c = word_match(req_q.addr, LED_ADDR);
  assign hit_sw_c  = word_match(req_q.addr, SW_ADDR);
  assign hit_cnt_c = word_match(req_q.addr, CNT_ADDR);

  mio_ram #(.RAM_WORDS(RAM_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (commit_c & hit_ram_c),
    .addr_i  (req_q.addr[RAM_AW+1:2]),
    .wdata_i (req_q.wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else if (commit_c && hit_led_c) begin
      led_q <= req_q.wdata[LED_W-1:0];
    end
  end

  // Free-running counter; a CPU write overrides the increment.
  always_comb begin
    cnt_d = cnt_q + DATA_W'(1);
    if (commit_c && hit_cnt_c) cnt_d = req_q.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    rdata_c = '0;
    if (resp_c && !req_q.we) begin
      if (hit_ram_c)      rdata_c = ram_rdata;
      else if (hit_led_c) rdata_c = DATA_W'(led_q);
      else if (hit_sw_c)  rdata_c = DATA_W'(sw_in);
      else if (hit_cnt_c) rdata_c = cnt_q;
    end
  end

  assign Data_in   = rdata_c;
  assign MIO_ready = resp_c;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench: three responders (WAIT_CYCLES 1, 0, 3) driven by a vector
// table plus hand-written counter, back-to-back, hold and reset-abort sequences.
module tb_mio_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst, cpu_mio, mem_w, ready;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [15:0] sw [3];
  logic [15:0] led [3];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mio_responder #(
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .RAM_WORDS  (256)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .CPU_MIO   (cpu_mio[g]),
      .mem_w     (mem_w[g]),
      .Addr_out  (addr[g]),
      .Data_out  (wdata[g]),
      .sw_in     (sw[g]),
      .Data_in   (rdata[g]),
      .MIO_ready (ready[g]),
      .led_out   (led[g])
    );
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // One access: present at a negedge, wait for the strobe, release there.
  task automatic do_access(input int idx, input logic we, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output int lat, output int zero_bad);
    @(negedge clk);
    cpu_mio[idx] = 1'b1;
    mem_w[idx]   = we;
    addr[idx]    = a;
    wdata[idx]   = d;
    lat = -1;
    zero_bad = 0;
    rd = '0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (ready[idx]) begin
        lat = k;
        rd  = rdata[idx];
        break;
      end
      if (rdata[idx] != 32'h0) zero_bad++;
    end
    cpu_mio[idx] = 1'b0;
    mem_w[idx]   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, zb, c0, cw, cr, seen;

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "ram_wr_10"});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ram_rd_10"});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, "ram_rd_lsb_ignored"});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, "ram_wr_0"});
    vecs.push_back('{1'b1, 32'h0000_0400, 32'h2222_2222, 32'h0, "wr_past_ram"});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, "ram_rd_0"});
    vecs.push_back('{1'b0, 32'h0000_0400, 32'h0, 32'h0, "rd_past_ram"});
    vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0, "ram_wr_last"});
    vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0, 32'h0BAD_F00D, "ram_rd_last"});
    vecs.push_back('{1'b1, 32'hE000_0000, 32'hABCD_1234, 32'h0, "led_wr"});
    vecs.push_back('{1'b0, 32'hE000_0000, 32'h0, 32'h0000_1234, "led_rd"});
    vecs.push_back('{1'b1, 32'hF000_0000, 32'h0000_1234, 32'h0, "sw_wr"});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h0000_1234, 32'h0, "unmapped_wr"});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0, 32'h0, "unmapped_rd"});
    vecs.push_back('{1'b0, 32'hF000_0000, 32'h0, 32'h0000_5A3C, "sw_rd"});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ram_rd_10_again"});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, "ram_rd_0_again"});

    rst = 3'b111;
    cpu_mio = '0;
    mem_w = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
    end
    sw[0] = 16'h5A3C;
    sw[1] = 16'h00A5;
    sw[2] = 16'h0F0F;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready[%0d]", i), 32'(ready[i]), 32'h0);
      check($sformatf("reset_data[%0d]", i), rdata[i], 32'h0);
      check($sformatf("reset_led[%0d]", i), 32'(led[i]), 32'h0);
    end
    rst = 3'b000;
    c0 = cyc;

    // Counter starts from 0 on the cycle reset is released.
    do_access(0, 1'b0, 32'hF000_0004, 32'h0, rd, lat, zb);
    cr = cyc;
    check("cnt_after_reset", rd, 32'(cr - c0));

    foreach (vecs[i]) begin
      do_access(0, vecs[i].we, vecs[i].a, vecs[i].d, rd, lat, zb);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
      check({vecs[i].name, "_idle_data"}, 32'(zb), 32'd0);
      if (!vecs[i].we) check(vecs[i].name, rd, vecs[i].exp);
    end
    check("led_out_after_table", 32'(led[0]), 32'h0000_1234);

    // Counter wrap: value just after the write edge is 0xFFFF_FFFE.
    do_access(0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, rd, lat, zb);
    cw = cyc;
    @(negedge clk);
    do_access(0, 1'b0, 32'hF000_0004, 32'h0, rd, lat, zb);
    cr = cyc;
    check("cnt_wrap_model", rd, 32'hFFFF_FFFE + 32'(cr - cw - 1));
    check("cnt_wrap_value", rd, 32'h0000_0001);

    // Zero-wait back-to-back switch reads: strobe every second cycle.
    @(negedge clk);
    cpu_mio[1] = 1'b1;
    mem_w[1]   = 1'b0;
    addr[1]    = 32'hF000_0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", k), 32'(ready[1]), 32'(k % 2));
      check($sformatf("b2b_data_%0d", k), rdata[1], (k % 2 == 1) ? 32'h0000_00A5 : 32'h0);
    end
    cpu_mio[1] = 1'b0;
    do_access(1, 1'b1, 32'h0000_0040, 32'h7777_0040, rd, lat, zb);
    check("w0_wr_latency", 32'(lat), 32'd1);
    do_access(1, 1'b0, 32'h0000_0040, 32'h0, rd, lat, zb);
    check("w0_rd_latency", 32'(lat), 32'd1);
    check("w0_rd_data", rd, 32'h7777_0040);

    // Three wait states; changed inputs during WAIT must be ignored.
    do_access(2, 1'b1, 32'h0000_0020, 32'hCAFE_0001, rd, lat, zb);
    check("w3_wr_latency", 32'(lat), 32'd4);
    do_access(2, 1'b1, 32'h0000_0024, 32'hCAFE_0002, rd, lat, zb);
    @(negedge clk);
    cpu_mio[2] = 1'b1;
    mem_w[2]   = 1'b0;
    addr[2]    = 32'h0000_0020;
    @(negedge clk);
    addr[2]    = 32'h0000_0024;
    mem_w[2]   = 1'b1;
    wdata[2]   = 32'hFFFF_FFFF;
    lat = -1;
    rd = '0;
    for (int k = 2; k <= 32; k++) begin
      @(negedge clk);
      if (ready[2]) begin
        lat = k;
        rd = rdata[2];
        break;
      end
    end
    cpu_mio[2] = 1'b0;
    mem_w[2]   = 1'b0;
    check("hold_latency", 32'(lat), 32'd4);
    check("hold_data", rd, 32'hCAFE_0001);
    do_access(2, 1'b0, 32'h0000_0024, 32'h0, rd, lat, zb);
    check("hold_no_write", rd, 32'hCAFE_0002);

    // Reset in WAIT abandons the LED write.
    @(negedge clk);
    cpu_mio[2] = 1'b1;
    mem_w[2]   = 1'b1;
    addr[2]    = 32'hE000_0000;
    wdata[2]   = 32'h0000_5555;
    @(negedge clk);
    rst[2]     = 1'b1;
    cpu_mio[2] = 1'b0;
    mem_w[2]   = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready[2]) seen++;
    end
    rst[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready[2]) seen++;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_led_out", 32'(led[2]), 32'h0);
    do_access(2, 1'b0, 32'hE000_0000, 32'h0, rd, lat, zb);
    check("abort_led_rd", rd, 32'h0);
    do_access(2, 1'b0, 32'h0000_0020, 32'h0, rd, lat, zb);
    check("abort_ram_intact", rd, 32'hCAFE_0001);
    check("abort_rd_latency", 32'(lat), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mio_responder.md
MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: wait states inserted before each response (0..15).
REQ-002 Parameter RAM_WORDS, default 256: data RAM depth in 32-bit words (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 CPU_MIO  input  1  request valid from CPU; held with address and data until MIO_ready.
REQ-006 mem_w  input  1  1 = write request, 0 = read request.
REQ-007 Addr_out  input  32  byte address from CPU; bits [1:0] ignored.
REQ-008 Data_out  input  32  write data from CPU.
REQ-009 sw_in  input  16  switch inputs, read-only peripheral.
REQ-010 Data_in  output  32  read data to CPU; valid only while MIO_ready=1.
REQ-011 MIO_ready  output  1  one-cycle response strobe completing the current request.
REQ-012 led_out  output  16  LED register contents.

Function
REQ-013 FSM states IDLE, WAIT, RESP; IDLE with CPU_MIO=1 latches mem_w, address and write data, then goes to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-014 WAIT loads a counter with WAIT_CYCLES-1 on entry, decrements once per cycle, and moves to RESP when it reaches 0.
REQ-015 RESP lasts exactly one cycle with MIO_ready=1; the next state is always IDLE.
REQ-016 Latency: request first seen in IDLE at cycle N gives MIO_ready=1 at cycle N+1+WAIT_CYCLES.
REQ-017 A new request is accepted in the IDLE cycle right after RESP; back-to-back throughput is one access per 2+WAIT_CYCLES cycles.
REQ-018 Changes to inputs outside IDLE are ignored; only the latched request is served.
REQ-019 Address map (word-aligned):
  - 0x0000_0000 + 4*i, i < RAM_WORDS: RAM read/write.
  - 0xE000_0000: LED register, read/write; bits [15:0] used, read returns zero-extended.
  - 0xF000_0000: switches, read-only, zero-extended sw_in sampled in the RESP cycle.
  - 0xF000_0004: 32-bit free-running counter, read/write.
REQ-020 All writes (RAM, LED, counter) commit on the RESP clock edge, and only there.
REQ-021 Read data is valid in the RESP cycle; Data_in=0 in every other cycle.
REQ-022 Unmapped addresses: a read returns 0, a write is discarded; the handshake still completes normally.
REQ-023 Writes to the switch address are discarded.
REQ-024 The counter increments every cycle and wraps from 0xFFFF_FFFF to 0; a write loads Data_out exactly, and that write wins over the increment in the same cycle.
REQ-025 A counter read returns the value held at the start of the RESP cycle.

Reset
REQ-026 Reset forces: state IDLE, MIO_ready=0, Data_in=0, led_out=0, counter=0, wait counter=0.
REQ-027 RAM contents are not affected by reset.
REQ-028 Reset during WAIT or RESP abandons the access; no write commits and no MIO_ready pulse is produced.

Structure
REQ-029 A shared package holds: address constants (RAM base, LED, SW, CNT), the FSM state encoding, and the WAIT_CYCLES width.
REQ-030 The RAM is a sub-module, mio_ram: synchronous write, combinational read, parameterised by RAM_WORDS.

Verification
REQ-031 Read test: WAIT_CYCLES=1; write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 -> MIO_ready 2 cycles after request; Data_in=0xDEAD_BEEF.
REQ-032 Zero-wait test: WAIT_CYCLES=0; back-to-back reads of 0xF000_0000 with sw_in=0x00A5 -> MIO_ready every 2nd cycle; Data_in=0x0000_00A5.
REQ-033 Counter test: write 0xFFFF_FFFE to 0xF000_0004, then read it 2 cycles later -> counter wraps through 0; read value matches the model.
REQ-034 Unmapped/read-only test: write 0x1234 to 0xF000_0000 and to 0x8000_0000 -> handshake completes; later reads return 0x0 for 0x8000_0000 and sw_in for 0xF000_0000.
REQ-035 Reset abort test: issue a write of 0x5555 to LED with WAIT_CYCLES=3, assert reset in WAIT -> no MIO_ready pulse, led_out=0; RAM data written before reset is still intact.
REQ-036 Hold test: change Addr_out during WAIT -> the response uses the latched address.
